// File: rtl/rs_stream_checker_if.sv
// rs_stream_checker_if: expected-symbol push channel and decoder output channel.
interface rs_stream_checker_if #(parameter int SYM_W = 8);
    logic             exp_valid;
    logic             exp_ready;
    logic [SYM_W-1:0] exp_byte;
    logic             dut_valid;
    logic             dut_ceo;
    logic [SYM_W-1:0] dut_byte;
    modport master (output exp_valid, exp_byte, dut_valid, dut_ceo, dut_byte, input exp_ready);
    modport slave  (input exp_valid, exp_byte, dut_valid, dut_ceo, dut_byte, output exp_ready);
endinterface

// File: rtl/rs_stream_checker.sv
// rs_stream_checker: FIFO-backed RS(204,188) decoder output checker with per-block and run-level error tallies.
// Define RS_CHK_FIRST_ERR_EN to add capture of the first mismatch in a run.
module rs_stream_checker #(
    parameter int SYM_W      = 8,
    parameter int BLK_LEN    = 188,
    parameter int NUM_BLOCKS = 100,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24,
    parameter int BLK_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    rs_stream_checker_if.slave s,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [BLK_W-1:0]  blk_cnt,
    output logic [BLK_W-1:0]  bad_blk_cnt,
    output logic              blk_done,
`ifdef RS_CHK_FIRST_ERR_EN
    output logic              first_err_valid,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [SYM_W-1:0]  first_err_exp,
    output logic [SYM_W-1:0]  first_err_got,
`endif
    output logic              underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = BLK_LEN > 1 ? $clog2(BLK_LEN) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [SYM_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic [IW-1:0]    sym_idx;
    logic             blk_err, full, empty, push, cmp, pop, mis, last, clr;
    logic [SYM_W-1:0] head;
`ifdef RS_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] sym_cnt;
`endif
    assign full        = occ == (AW+1)'(FIFO_DEPTH);
    assign empty       = occ == '0;
    assign s.exp_ready = !full;
    assign push        = s.exp_valid && !full;
    // Once the final block has closed, stray strobes in the hand-off cycle to DONE are ignored.
    assign cmp         = state == RUN && s.dut_valid && s.dut_ceo && blk_cnt != BLK_W'(NUM_BLOCKS);
    assign pop         = cmp && !empty;
    assign head        = mem[rd_ptr];
    assign mis         = cmp && (empty || s.dut_byte != head);
    assign last        = cmp && sym_idx == IW'(BLK_LEN - 1);
    assign clr         = start && state != RUN;
    assign busy        = state == RUN;
    assign done        = state == DONE;
    assign pass        = done && err_cnt == '0 && !underflow;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s.exp_byte;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            sym_idx     <= '0;
            blk_err     <= 1'b0;
            err_cnt     <= '0;
            blk_cnt     <= '0;
            bad_blk_cnt <= '0;
            blk_done    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            occ      <= occ + (AW+1)'(push) - (AW+1)'(pop);
            blk_done <= last;
            if (clr) begin
                state       <= RUN;
                sym_idx     <= '0;
                blk_err     <= 1'b0;
                err_cnt     <= '0;
                blk_cnt     <= '0;
                bad_blk_cnt <= '0;
                underflow   <= 1'b0;
            end else begin
                if (state == RUN && blk_cnt == BLK_W'(NUM_BLOCKS)) state <= DONE;
                if (cmp) begin
                    sym_idx <= last ? '0 : sym_idx + IW'(1);
                    blk_err <= !last && (blk_err || mis);
                    if (empty) underflow <= 1'b1;
                    if (mis && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
                    if (last) blk_cnt <= blk_cnt + BLK_W'(1);
                    if (last && (blk_err || mis) && !(&bad_blk_cnt)) bad_blk_cnt <= bad_blk_cnt + BLK_W'(1);
                end
            end
        end
    end
`ifdef RS_CHK_FIRST_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else if (clr) begin
            sym_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            if (cmp) sym_cnt <= sym_cnt + CNT_W'(1);
            if (mis && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= sym_cnt;
                first_err_exp   <= empty ? '0 : head;
                first_err_got   <= s.dut_byte;
            end
        end
    end
`endif
endmodule
